// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable dividers producing 50% divided clocks
// or one-cycle strobes, with per-channel run-time divisor/mode and a global phase clear.
module clock_divider_bank #(
    parameter int          NUM_CH      = 4,
    parameter int          WIDTH       = 25,
    parameter int          CH_BITS     = 2,
    parameter int unsigned DEFAULT_DIV = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_CH-1:0]  en,
    input  logic               sync_clr,
    input  logic               wr_en,
    input  logic [CH_BITS-1:0] wr_ch,
    input  logic [WIDTH-1:0]   wr_div,
    input  logic               wr_mode,
    output logic [NUM_CH-1:0]  div_out,
    output logic [NUM_CH-1:0]  tick
);

    localparam logic [WIDTH-1:0]   DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);
    localparam logic [CH_BITS:0]   NUM_CH_W = (CH_BITS + 1)'(NUM_CH);

    // Writes to channel indices beyond the bank must not alias onto a real channel.
    logic wr_valid;
    assign wr_valid = wr_en && ({1'b0, wr_ch} < NUM_CH_W);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] div_q,   div_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic             mode_q,  mode_d;
        logic             out_q,   out_d;
        logic             tick_q,  tick_d;
        logic             wr_hit;
        logic             terminal;

        assign wr_hit   = wr_valid && (wr_ch == CH_BITS'(i));
        assign terminal = (count_q == div_q - ONE);

        // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
        always_comb begin
            div_d   = div_q;
            mode_d  = mode_q;
            count_d = count_q;
            out_d   = out_q;
            tick_d  = 1'b0;
            if (sync_clr) begin
                count_d = '0;
                out_d   = 1'b0;
            end else if (wr_hit) begin
                div_d   = wr_div;
                mode_d  = wr_mode;
                count_d = '0;
                out_d   = 1'b0;
            end else if (div_q == '0) begin
                count_d = '0;
                out_d   = 1'b0;
            end else if (en[i]) begin
                if (terminal) begin
                    count_d = '0;
                    tick_d  = 1'b1;
                    out_d   = mode_q ? 1'b1 : ~out_q;
                end else begin
                    count_d = count_q + ONE;
                    out_d   = mode_q ? 1'b0 : out_q;
                end
            end
        end

        // NOTE: sequential state uses non-blocking assignments so all channels update from the same pre-edge values.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                div_q   <= DEF_DIV;
                mode_q  <= 1'b0;
                count_q <= '0;
                out_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                div_q   <= div_d;
                mode_q  <= mode_d;
                count_q <= count_d;
                out_q   <= out_d;
                tick_q  <= tick_d;
            end
        end

        assign div_out[i] = out_q;
        assign tick[i]    = tick_q;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Multi-channel programmable clock-enable/divided-clock generator, next generation of the single-channel fixed-divisor toggler.
- NUM_CH independent channels; per-channel divisor and mode written at run time, plus a per-channel enable and a global phase-align clear.
- Feeds slow-rate strobes to the display, animation and debounce logic from the single system clock.

Parameters:
- NUM_CH, 4, number of divider channels (1..16)
- WIDTH, 25, divisor/counter width in bits
- CH_BITS, 2, width of channel-select field; must satisfy 2**CH_BITS >= NUM_CH
- DEFAULT_DIV, 25000000, divisor loaded into every channel at reset; must fit in WIDTH bits

Ports:
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel count enable
- sync_clr  in  1  synchronous restart of all channels (phase align)
- wr_en  in  1  configuration write strobe, one cycle
- wr_ch  in  CH_BITS  channel index for the write
- wr_div  in  WIDTH  new divisor D
- wr_mode  in  1  new mode: 0 = toggle (50% divided clock), 1 = pulse
- div_out  out  NUM_CH  per-channel divided clock (toggle mode) or strobe (pulse mode), registered
- tick  out  NUM_CH  per-channel one-cycle terminal-count strobe, registered

Behaviour:
- Clock is named clock and reset is named reset. Reset is asynchronous and active-high. Reset applies to every register.
- Per-channel state: div[WIDTH], mode, count[WIDTH], out, tick.
- Reset values: div=DEFAULT_DIV, mode=0, count=0, div_out=0, tick=0 for all channels.
- Priority per channel, highest first: reset > sync_clr > write to this channel > normal counting.
- sync_clr: all channels get count=0, div_out=0, tick=0. div and mode are kept. Any write in the same cycle is discarded.
- Write (wr_en=1, wr_ch<NUM_CH): the addressed channel loads div=wr_div and mode=wr_mode, then restarts with count=0, div_out=0, tick=0. The new settings take effect from the next edge. Other channels are unaffected.
- A write with wr_ch>=NUM_CH is ignored entirely.
- Counting applies when en[i]=1 and D>=1, with no write and no clear this edge:
  - if count==D-1: count becomes 0 and tick becomes 1. In toggle mode div_out inverts; in pulse mode div_out becomes 1.
  - otherwise: count becomes count+1 and tick becomes 0. In pulse mode div_out becomes 0; in toggle mode div_out holds.
- Resulting timing: tick is high for exactly one cycle every D enabled cycles. In toggle mode div_out has period 2*D cycles at 50% duty. In pulse mode div_out equals tick.
- D=1: tick is high continuously. Toggle mode gives clock/2. Pulse mode holds div_out high.
- D=0: channel idle. count=0, tick=0, div_out=0 held.
- en[i]=0: count and div_out hold, tick=0. Counting resumes from the held count with no lost or extra cycle.
- Latency: after a restart (reset release, clear or write), the first tick occurs at the D-th enabled rising edge and is visible in the following cycle.
- Counter arithmetic is unsigned WIDTH-bit. count never exceeds D-1, so there is no wrap-around beyond the terminal count.
- Reset asserted mid-count forces the reset values immediately, without waiting for a clock edge. Release resumes counting with DEFAULT_DIV.

Test Plan:
- Reset release, NUM_CH=4, DEFAULT_DIV=4, en=4'hF -> every tick pulses at edges 4,8,12; every div_out toggles at those edges (period 8 cycles, 50% duty).
- Write ch2 with D=3, mode=1, mid-count -> ch2 tick and div_out go to 0 on the write edge, then pulse together every 3 cycles starting 3 edges later; ch0, ch1 and ch3 continue undisturbed.
- en[1] dropped for 5 cycles at count=2 with D=4 -> div_out[1] and count frozen, tick[1]=0; after re-enable the next tick arrives 2 enabled edges later.
- sync_clr asserted together with a write to ch0 -> all counts and outputs are 0; ch0 keeps its old div and mode, and the write is lost.
- Write D=0 then D=1 in toggle mode -> with D=0 the channel stays silent; with D=1 tick is held high and div_out toggles every cycle. A write with wr_ch=5 (CH_BITS=3, NUM_CH=4) produces no state change.
- Assert reset asynchronously between clock edges while counting -> outputs go to 0 before the next edge; divisors are restored to DEFAULT_DIV.
